// File: rtl/wb_merge_if.sv
// wb_merge_if: completion-channel requests and register-file write port of wb_merge_stage
interface wb_merge_if #(
   parameter int NUM_CH = 2,
   parameter int XLEN   = 32
);
   localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   logic                     flush_i;
   logic [NUM_CH-1:0]        ch_valid_i;
   logic [NUM_CH-1:0]        ch_ready_o;
   logic [NUM_CH-1:0]        ch_reg_write_i;
   logic [5*NUM_CH-1:0]      ch_rd_i;
   logic [2*NUM_CH-1:0]      ch_wb_sel_i;
   logic [XLEN*NUM_CH-1:0]   ch_alu_res_i;
   logic [XLEN*NUM_CH-1:0]   ch_mem_data_i;
   logic [XLEN*NUM_CH-1:0]   ch_pc_i;
   logic                     reg_write_o;
   logic [4:0]               rd_addr_o;
   logic [XLEN-1:0]          rd_data_o;
   logic [CW-1:0]            grant_ch_o;
   logic                     idle_o;
   modport master (
      output flush_i, ch_valid_i, ch_reg_write_i, ch_rd_i, ch_wb_sel_i,
             ch_alu_res_i, ch_mem_data_i, ch_pc_i,
      input  ch_ready_o, reg_write_o, rd_addr_o, rd_data_o, grant_ch_o, idle_o
   );
   modport slave (
      input  flush_i, ch_valid_i, ch_reg_write_i, ch_rd_i, ch_wb_sel_i,
             ch_alu_res_i, ch_mem_data_i, ch_pc_i,
      output ch_ready_o, reg_write_o, rd_addr_o, rd_data_o, grant_ch_o, idle_o
   );
endinterface

// File: rtl/wb_merge_stage.sv
// wb_merge_stage: per-channel writeback FIFOs merged round-robin onto one register-file write port
module wb_merge_stage #(
   parameter int NUM_CH = 2,
   parameter int XLEN   = 32,
   parameter int DEPTH  = 2
) (
   input logic       clk,
   input logic       rst_n,
   wb_merge_if.slave bus
);
   localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int AW = $clog2(DEPTH + 1);
   logic [NUM_CH-1:0]           enq, deq, ready_nx;
   logic [NUM_CH-1:0][AW-1:0]   cnt, cnt_nx;
   logic [NUM_CH-1:0][4:0]      head_rd;
   logic [NUM_CH-1:0][XLEN-1:0] head_data;
   logic [CW-1:0]               ptr, win;
   logic                        gnt, fire, idle_nx;
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [4:0]      mem_rd   [DEPTH];
      logic [XLEN-1:0] mem_data [DEPTH];
      logic [PW-1:0]   hd, tl;
      logic [AW-1:0]   n;
      logic [1:0]      sel;
      logic [4:0]      rd;
      logic [XLEN-1:0] wdata;
      assign sel   = bus.ch_wb_sel_i[2*k +: 2];
      assign rd    = bus.ch_rd_i[5*k +: 5];
      assign wdata = sel == 2'd0 ? bus.ch_alu_res_i[XLEN*k +: XLEN] :
                     sel == 2'd1 ? bus.ch_mem_data_i[XLEN*k +: XLEN] :
                     sel == 2'd2 ? bus.ch_pc_i[XLEN*k +: XLEN] + XLEN'(4) : '0;
      // non-writing completions are acknowledged without taking a slot
      assign enq[k]      = bus.ch_valid_i[k] & bus.ch_ready_o[k] & bus.ch_reg_write_i[k] &
                           (rd != 5'd0) & ~bus.flush_i;
      assign deq[k]      = fire & (win == CW'(k));
      assign cnt[k]      = n;
      assign cnt_nx[k]   = bus.flush_i ? '0 : n + AW'(enq[k]) - AW'(deq[k]);
      assign ready_nx[k] = cnt_nx[k] != AW'(DEPTH);
      assign head_rd[k]  = mem_rd[hd];
      assign head_data[k] = mem_data[hd];
      always_ff @(posedge clk)
         if (enq[k]) begin
            mem_rd[tl]   <= rd;
            mem_data[tl] <= wdata;
         end
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            hd <= '0;
            tl <= '0;
            n  <= '0;
         end else begin
            hd <= bus.flush_i ? '0 : hd + PW'(deq[k]);
            tl <= bus.flush_i ? '0 : tl + PW'(enq[k]);
            n  <= cnt_nx[k];
         end
   end
   // search starts one past the last winner so every channel is reached within NUM_CH grants
   always_comb begin
      gnt = 1'b0;
      win = '0;
      for (int i = 1; i <= NUM_CH; i++)
         if (!gnt && cnt[(int'(ptr) + i) % NUM_CH] != '0) begin
            gnt = 1'b1;
            win = CW'((int'(ptr) + i) % NUM_CH);
         end
   end
   assign fire    = gnt & ~bus.flush_i;
   assign idle_nx = ~|cnt_nx & ~fire;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.reg_write_o <= 1'b0;
         bus.rd_addr_o   <= '0;
         bus.rd_data_o   <= '0;
         bus.grant_ch_o  <= '0;
         bus.ch_ready_o  <= '0;
         bus.idle_o      <= 1'b1;
         ptr             <= CW'(NUM_CH - 1);
      end else begin
         bus.reg_write_o <= fire;
         bus.ch_ready_o  <= ready_nx;
         bus.idle_o      <= idle_nx;
         if (fire) begin
            bus.rd_addr_o  <= head_rd[win];
            bus.rd_data_o  <= head_data[win];
            bus.grant_ch_o <= win;
            ptr            <= win;
         end
      end
endmodule

// File: tb/tb_wb_merge_stage.sv
// tb_wb_merge_stage: directed scoreboard bench for wb_merge_stage (2 channels, DEPTH 2)
module tb_wb_merge_stage;
   typedef struct packed {
      logic        rw;
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic [31:0] alu;
      logic [31:0] mem;
      logic [31:0] pc;
   } req_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   wb_merge_if #(.NUM_CH(2), .XLEN(32)) bus ();
   wb_merge_stage #(.NUM_CH(2), .XLEN(32), .DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int          checks = 0;
   int          failures = 0;
   req_t        src0[$], src1[$];
   logic [36:0] exp0[$], exp1[$];
   logic [5:0]  wlog[$];
   logic        flush_req = 1'b0;
   logic        saw_stall0 = 1'b0;
   function automatic req_t mk(logic rw, logic [4:0] rd, logic [1:0] sel,
                               logic [31:0] alu, logic [31:0] mem, logic [31:0] pc);
      req_t r;
      r.rw = rw; r.rd = rd; r.sel = sel; r.alu = alu; r.mem = mem; r.pc = pc;
      return r;
   endfunction
   function automatic logic [31:0] wb_val(req_t r);
      case (r.sel)
         2'd0:    return r.alu;
         2'd1:    return r.mem;
         2'd2:    return r.pc + 32'd4;
         default: return 32'd0;
      endcase
   endfunction
   task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask
   task automatic timeout(string tag);
      checks++;
      failures++;
      $error("FAIL %s observed=timeout expected=completion", tag);
   endtask
   task automatic wait_sent();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (src0.size() == 0 && src1.size() == 0) return;
      end
      timeout("send");
   endtask
   task automatic settle();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #1;
         if (src0.size() == 0 && src1.size() == 0 && exp0.size() == 0 &&
             exp1.size() == 0 && !bus.reg_write_o) return;
      end
      timeout("settle");
   endtask
   // driver + monitor: present queue heads, retire transfers, score every write
   initial begin
      logic [1:0]  xfer;
      logic        flush_was;
      logic [36:0] e;
      req_t        r;
      xfer = '0;
      flush_was = 1'b0;
      bus.flush_i = 1'b0;
      bus.ch_valid_i = '0;
      bus.ch_reg_write_i = '0;
      bus.ch_rd_i = '0;
      bus.ch_wb_sel_i = '0;
      bus.ch_alu_res_i = '0;
      bus.ch_mem_data_i = '0;
      bus.ch_pc_i = '0;
      forever begin
         @(negedge clk);
         if (bus.reg_write_o) begin
            wlog.push_back({bus.grant_ch_o, bus.rd_addr_o});
            e = 'x;
            if (bus.grant_ch_o == 1'b0 && exp0.size() > 0) e = exp0.pop_front();
            else if (bus.grant_ch_o == 1'b1 && exp1.size() > 0) e = exp1.pop_front();
            chk("write", {27'd0, bus.rd_addr_o, bus.rd_data_o}, {27'd0, e});
         end
         if (!bus.ch_ready_o[0]) saw_stall0 = 1'b1;
         if (xfer[0] && src0.size() > 0) begin
            r = src0.pop_front();
            if (!flush_was && r.rw && r.rd != 5'd0) exp0.push_back({r.rd, wb_val(r)});
         end
         if (xfer[1] && src1.size() > 0) begin
            r = src1.pop_front();
            if (!flush_was && r.rw && r.rd != 5'd0) exp1.push_back({r.rd, wb_val(r)});
         end
         if (flush_was) begin
            exp0.delete(); exp1.delete(); src0.delete(); src1.delete();
         end
         bus.flush_i = flush_req;
         flush_req = 1'b0;
         bus.ch_valid_i = '0;
         if (src0.size() > 0) begin
            r = src0[0];
            bus.ch_valid_i[0] = 1'b1;
            bus.ch_reg_write_i[0] = r.rw;
            bus.ch_rd_i[4:0] = r.rd;
            bus.ch_wb_sel_i[1:0] = r.sel;
            bus.ch_alu_res_i[31:0] = r.alu;
            bus.ch_mem_data_i[31:0] = r.mem;
            bus.ch_pc_i[31:0] = r.pc;
         end
         if (src1.size() > 0) begin
            r = src1[0];
            bus.ch_valid_i[1] = 1'b1;
            bus.ch_reg_write_i[1] = r.rw;
            bus.ch_rd_i[9:5] = r.rd;
            bus.ch_wb_sel_i[3:2] = r.sel;
            bus.ch_alu_res_i[63:32] = r.alu;
            bus.ch_mem_data_i[63:32] = r.mem;
            bus.ch_pc_i[63:32] = r.pc;
         end
         xfer = bus.ch_valid_i & bus.ch_ready_o;
         flush_was = bus.flush_i;
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int          n;
      logic        idle_ok;
      logic [5:0]  rr_exp [8];
      rr_exp = '{6'd1, 6'd43, 6'd2, 6'd44, 6'd3, 6'd45, 6'd4, 6'd46};
      #12;
      chk("rst_reg_write", bus.reg_write_o, 0);
      chk("rst_ready", bus.ch_ready_o, 0);
      chk("rst_idle", bus.idle_o, 1);
      chk("rst_rd_addr", bus.rd_addr_o, 0);
      chk("rst_rd_data", bus.rd_data_o, 0);
      chk("rst_grant", bus.grant_ch_o, 0);
      @(negedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_release", bus.ch_ready_o, 2'b11);
      // reset while a write is still buffered
      src0.push_back(mk(1, 5, 0, 32'h1234, 0, 0));
      wait_sent();
      rst_n = 1'b0;
      #1;
      chk("midrst_reg_write", bus.reg_write_o, 0);
      chk("midrst_ready", bus.ch_ready_o, 0);
      exp0.delete(); exp1.delete();
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_ready_release", bus.ch_ready_o, 2'b11);
      repeat (4) @(negedge clk);
      settle();
      chk("midrst_idle", bus.idle_o, 1);
      // two-edge latency and PC+4 select
      src1.push_back(mk(1, 7, 2, 0, 0, 32'h100));
      wait_sent();
      chk("lat_e0_no_write", bus.reg_write_o, 0);
      @(negedge clk); #1;
      chk("lat_e1_write", bus.reg_write_o, 1);
      chk("lat_rd", bus.rd_addr_o, 7);
      chk("lat_data", bus.rd_data_o, 32'h104);
      chk("lat_grant", bus.grant_ch_o, 1);
      settle();
      src1.push_back(mk(1, 8, 2, 0, 0, 32'hFFFF_FFFC));
      settle();
      chk("pc_wrap_rd", bus.rd_addr_o, 8);
      chk("pc_wrap_data", bus.rd_data_o, 0);
      // filtered completions: accepted, never written
      n = wlog.size();
      src0.push_back(mk(0, 9, 0, 32'hAA, 0, 0));
      src0.push_back(mk(1, 0, 1, 0, 32'hBB, 0));
      idle_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         if (!bus.idle_o) idle_ok = 1'b0;
      end
      chk("filter_idle", idle_ok, 1);
      chk("filter_accepted", src0.size(), 0);
      chk("filter_no_write", wlog.size(), n);
      src0.push_back(mk(1, 3, 3, 32'hDEAD, 32'hBEEF, 32'h40));
      settle();
      chk("zero_sel_rd", bus.rd_addr_o, 3);
      chk("zero_sel_data", bus.rd_data_o, 0);
      // back-pressure with both channels busy
      saw_stall0 = 1'b0;
      n = wlog.size();
      for (int i = 0; i < 4; i++) begin
         src0.push_back(mk(1, 5'(21 + i), 0, 32'(32'h11 * (i + 1)), 0, 0));
         src1.push_back(mk(1, 5'(25 + i), 1, 0, 32'(32'h500 + i), 0));
      end
      settle();
      chk("bp_stall", saw_stall0, 1);
      chk("bp_writes", wlog.size() - n, 8);
      // round-robin from a fresh reset: channel 0 first
      @(negedge clk); #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      wlog.delete();
      for (int i = 0; i < 4; i++) begin
         src0.push_back(mk(1, 5'(1 + i), 0, 32'(i + 100), 0, 0));
         src1.push_back(mk(1, 5'(11 + i), 0, 32'(i + 200), 0, 0));
      end
      settle();
      chk("rr_count", wlog.size(), 8);
      for (int i = 0; i < 8; i++) chk($sformatf("rr_%0d", i), wlog[i], rr_exp[i]);
      // flush with both FIFOs loaded and a channel-0 request in the same cycle
      for (int i = 0; i < 6; i++) begin
         src0.push_back(mk(1, 5'(16 + i), 0, 32'(i + 300), 0, 0));
         src1.push_back(mk(1, 5'(22 + i), 1, 0, 32'(i + 400), 0));
      end
      repeat (4) @(negedge clk);
      #1 flush_req = 1'b1;
      @(negedge clk); #1;
      chk("flush_ch0_req", bus.ch_valid_i[0], 1);
      @(negedge clk); #1;
      chk("flush_reg_write", bus.reg_write_o, 0);
      chk("flush_ready", bus.ch_ready_o, 2'b11);
      chk("flush_idle", bus.idle_o, 1);
      n = wlog.size();
      repeat (8) @(negedge clk);
      #1;
      chk("flush_no_stale", wlog.size(), n);
      settle();
      chk("end_idle", bus.idle_o, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_merge_stage.md
Name: wb_merge_stage

Overview:
Parametrised writeback stage that merges NUM_CH independent completion channels (e.g. ALU pipe, load pipe, mul/div unit) onto the single register-file write port.
- Per channel: valid/ready input, DEPTH-entry FIFO, writeback data mux (ALU / MEM / PC+4).
- Across channels: round-robin arbitration, one registered write per cycle.
- Sits between the execute/memory completion paths and the register file; adds back-pressure, flush and an idle indication.

Parameters:
NUM_CH, 2, number of completion channels (>=1)
XLEN, 32, data width
DEPTH, 2, FIFO entries per channel (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  discard all buffered and pending writes
ch_valid_i  in  NUM_CH  per-channel request valid
ch_ready_o  out  NUM_CH  per-channel accept, registered
ch_reg_write_i  in  NUM_CH  instruction writes rd
ch_rd_i  in  5*NUM_CH  destination register, channel k at [5k+:5]
ch_wb_sel_i  in  2*NUM_CH  0=ALU, 1=MEM, 2=PC+4, 3=zero
ch_alu_res_i  in  XLEN*NUM_CH  ALU result
ch_mem_data_i  in  XLEN*NUM_CH  load data
ch_pc_i  in  XLEN*NUM_CH  instruction PC
reg_write_o  out  1  register-file write enable, registered
rd_addr_o  out  5  write address, registered
rd_data_o  out  XLEN  write data, registered
grant_ch_o  out  max(1,$clog2(NUM_CH))  channel that produced the current write
idle_o  out  1  all FIFOs empty and reg_write_o low

Behaviour:
Reset (rst_n low, asynchronous):
- reg_write_o, rd_addr_o, rd_data_o, grant_ch_o, ch_ready_o = 0; idle_o = 1.
- FIFOs emptied; RR pointer = NUM_CH-1, so channel 0 has first priority.
- ch_ready_o rises at the first clk edge after deassertion.
- Reset mid-operation drops all pending writes.

Handshake:
- Transfer on channel k when ch_valid_i[k] & ch_ready_o[k] at a rising edge.
- ch_ready_o[k] = !full[k], registered from the post-edge count.
- A dequeue in the same cycle does not make a full FIFO ready combinationally.
- Inputs are sampled only on transfer; they may change freely while ready = 0.

Enqueue filter:
- A transfer with reg_write = 0 or rd = 0 is accepted but consumes no FIFO slot.
- Stored entry = {rd, data}, where data is the mux result computed at enqueue:
  - sel 0 → alu_res
  - sel 1 → mem_data
  - sel 2 → pc + 4, modulo 2^XLEN (0xFFFFFFFC → 0x00000000)
  - sel 3 → 0

FIFO:
- Head/tail pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Simultaneous enqueue and dequeue on a non-full, non-empty FIFO leaves count unchanged.
- Enqueue into an empty FIFO while another head is granted is legal.

Arbitration (combinational over FIFO heads, every cycle):
- Search channels starting at (ptr+1) mod NUM_CH; first non-empty channel wins.
- The winner dequeues at the edge; the pointer updates to the winner only on a grant.
- No starvation: a waiting channel is granted within NUM_CH writes.
- Ordering across channels is not preserved. Same-rd hazards are the issuing scoreboard's responsibility.
- Ordering within a channel is FIFO.

Output register:
- On a grant: reg_write_o = 1 and rd/data/grant_ch_o loaded.
- With no grant: reg_write_o = 0; rd_addr_o, rd_data_o, grant_ch_o hold.
- Latency: transfer at edge E0 → earliest reg_write_o high in the cycle after edge E1 (2 edges).

Flush:
- At the edge where flush_i = 1: all FIFOs emptied, reg_write_o cleared, RR pointer unchanged.
- Input transfers in that cycle are discarded.
- ch_ready_o = 1 for all channels after the edge.
- Flush takes priority over enqueue, dequeue and grant.

idle_o: registered; 1 when every count = 0 and reg_write_o = 0 after the edge.

Test Plan:
- Reset mid-write: inject ch0 {rd=5, sel=ALU, alu=0x1234}, pull rst_n low before the output → reg_write_o=0, ch_ready_o=0 immediately; after release, ch_ready_o=11 at the first edge, no stale write.
- Latency/mux: ch1 {rd=7, sel=PC, pc=0x100} at E0 → reg_write_o=1, rd=7, data=0x104, grant=1 after E1. pc=0xFFFFFFFC → data=0.
- Filtering: ch0 reg_write=0, then ch0 rd=0 sel=MEM → both accepted, no write, idle_o stays 1. sel=3 with rd=3 → write of 0 to x3.
- Back-pressure: hold ch0 valid for 4 consecutive requests, DEPTH=2, while ch1 is also busy → ch_ready_o[0] drops after 2 stored, never overflows; all 4 rd values are written in issue order.
- Round-robin: both channels continuously valid (rd=1..4 on ch0, 11..14 on ch1) → writes alternate 1, 11, 2, 12, …, grant_ch_o alternates 0, 1.
- Flush: fill both FIFOs, assert flush_i one cycle with a simultaneous ch0 request → next cycle reg_write_o=0, ch_ready_o=11, idle_o=1; the flushed-cycle request is never written.
